alu_mc: RTL

Parametrised multi-cycle successor to the datapath ALU: same base opcodes (ADD/SUB/AND/OR/XOR/SLT), plus unsigned compare, shifts and an iterative unsigned multiply/divide unit. Sits between register read and writeback in the core. Single-cycle ops return after one registered stage; MUL/DIV ops stall the issue side through a valid/ready handshake until done. Zero flag is registered alongside the result.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_muldiv.sv | 93 +++++++++
 rtl/alu_mc.sv | 103 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and opcode classification for alu_mc.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_MULHU = 4'd11;
    localparam logic [3:0] ALU_DIVU  = 4'd12;
    localparam logic [3:0] ALU_REMU  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Opcodes handled by the iterative mul/div unit
    function automatic logic is_multicycle(input logic [3:0] sel);
        return (sel >= ALU_MUL) && (sel <= ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// hi/lo hold {product high, multiplier/product low} for MUL, {remainder, quotient} for DIV.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic            run_q, run_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN:0]   sum, shifted;
    logic [XLEN+1:0] diff;
    logic            ge, is_mul;

    // One iteration step; done fires on the last step so the result is taken from the _d values
    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        op_d    = op_q;
        done    = 1'b0;
        is_mul  = (op_q == ALU_MUL) || (op_q == ALU_MULHU);
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, b_q};
        ge      = ~diff[XLEN+1];
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            hi_d  = '0;
            lo_d  = a;
            b_d   = b;
            op_d  = op;
        end else if (run_q) begin
            if (is_mul) begin
                hi_d = sum[XLEN:1];
                lo_d = {sum[0], lo_q[XLEN-1:1]};
            end else begin
                // Divide by zero falls out naturally: every step succeeds -> all-ones, rem = a
                hi_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], ge};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN - 1)) begin
                done  = 1'b1;
                run_d = 1'b0;
                cnt_d = '0;
            end
        end
    end

    // Pick the half of the final state that the opcode asks for
    always_comb begin
        case (op_q)
            ALU_MUL, ALU_DIVU: result = lo_d;
            default:           result = hi_d;
        endcase
    end

    // Iteration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            op_q  <= op_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops through one registered stage, MUL/DIV via alu_muldiv.
module alu_mc
    import alu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d, alu_res, md_result;
    logic            zero_q, zero_d, md_start, md_done, accept;
    logic [SHW-1:0]  shamt;

    assign out_valid = (state_q == ST_DONE);
    assign in_ready  = (state_q != ST_BUSY) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign result    = result_q;
    assign zero      = zero_q;
    assign shamt     = in2[SHW-1:0];

    // Combinational single-cycle datapath
    always_comb begin
        case (sel)
            ALU_ADD:  alu_res = in1 + in2;
            ALU_SUB:  alu_res = in1 - in2;
            ALU_AND:  alu_res = in1 & in2;
            ALU_OR:   alu_res = in1 | in2;
            ALU_XOR:  alu_res = in1 ^ in2;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
            ALU_SLL:  alu_res = in1 << shamt;
            ALU_SRL:  alu_res = in1 >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(in1) >>> shamt);
            default:  alu_res = '0;
        endcase
    end

    // Next-state, output-register load and mul/div start
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        md_start = 1'b0;
        case (state_q)
            ST_BUSY: begin
                if (md_done) begin
                    state_d  = ST_DONE;
                    result_d = md_result;
                    zero_d   = (md_result == '0);
                end
            end
            default: begin
                if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
                if (accept) begin
                    if (is_multicycle(sel)) begin
                        state_d  = ST_BUSY;
                        md_start = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                    end
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    alu_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (sel),
        .a      (in1),
        .b      (in2),
        .done   (md_done),
        .result (md_result)
    );

endmodule
